// File: rtl/ysyx_22041207_cache_pkg.sv
// Shared definitions for the load-side cache refill controller:
// bus widths, address field bounds and the controller state encoding.
package ysyx_22041207_cache_pkg;

  localparam int unsigned ADDR_W   = 64;
  localparam int unsigned DATA_W   = 64;

  localparam int unsigned OFF_HI   = 2;
  localparam int unsigned OFF_LO   = 0;
  localparam int unsigned INDEX_HI = 4;
  localparam int unsigned INDEX_LO = 3;
  localparam int unsigned TAG_HI   = 63;
  localparam int unsigned TAG_LO   = 5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOOKUP   = 3'd1,
    ST_MEM_REQ  = 3'd2,
    ST_MEM_WAIT = 3'd3,
    ST_FILL     = 3'd4,
    ST_RESP     = 3'd5
  } state_e;

endpackage

// File: rtl/ysyx_22041207_sat_counter.sv
// Saturating up-counter used for the hit/miss performance counters.
module ysyx_22041207_sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/ysyx_22041207_cache_refill.sv
// Blocking load path: cache lookup, single-beat memory refill on a miss,
// fill suppression when a store invalidates the in-flight line.
module ysyx_22041207_cache_refill #(
  parameter int unsigned ADDR_W = ysyx_22041207_cache_pkg::ADDR_W,
  parameter int unsigned DATA_W = ysyx_22041207_cache_pkg::DATA_W,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] lookup_addr,
  input  logic              hit,
  input  logic [DATA_W-1:0] hit_data,
  output logic              fill_en,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [DATA_W-1:0] fill_data,
  input  logic              inv_valid,
  input  logic [ADDR_W-1:0] inv_addr,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  import ysyx_22041207_cache_pkg::*;

  localparam int unsigned OFF_W   = OFF_HI - OFF_LO + 1;
  localparam int unsigned TAG_TOP = (TAG_HI < ADDR_W) ? TAG_HI : ADDR_W - 1;

  state_e            r_state;
  state_e            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_stale;
  logic              w_inv_hit;
  logic              w_hit_inc;
  logic              w_miss_inc;

  // Same line means same tag and index; the byte offset is irrelevant.
  assign w_inv_hit = inv_valid
                  && (inv_addr[TAG_TOP:TAG_LO]     == r_addr[TAG_TOP:TAG_LO])
                  && (inv_addr[INDEX_HI:INDEX_LO] == r_addr[INDEX_HI:INDEX_LO]);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (req_valid) w_next = ST_LOOKUP;
      ST_LOOKUP:   w_next = hit ? ST_RESP : ST_MEM_REQ;
      ST_MEM_REQ:  if (mem_req_ready) w_next = mem_rsp_valid ? ST_FILL : ST_MEM_WAIT;
      ST_MEM_WAIT: if (mem_rsp_valid) w_next = ST_FILL;
      ST_FILL:     w_next = ST_RESP;
      ST_RESP:     w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_data  <= '0;
      r_stale <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE:     if (req_valid) r_addr <= req_addr;
        ST_LOOKUP:   if (hit) r_data <= hit_data;
        ST_MEM_REQ:  if (mem_req_ready && mem_rsp_valid) r_data <= mem_rsp_data;
        ST_MEM_WAIT: if (mem_rsp_valid) r_data <= mem_rsp_data;
        default:     ;
      endcase
      if ((r_state == ST_IDLE) && req_valid) begin
        r_stale <= 1'b0;
      end else if (w_inv_hit && ((r_state == ST_MEM_REQ) || (r_state == ST_MEM_WAIT)
                                 || (r_state == ST_FILL))) begin
        r_stale <= 1'b1;
      end
    end
  end

  assign req_ready     = (r_state == ST_IDLE);
  assign rsp_valid     = (r_state == ST_RESP);
  assign rsp_data      = r_data;
  assign lookup_addr   = (r_state == ST_IDLE) ? req_addr : r_addr;
  // An invalidate landing in the fill cycle itself also blocks the write.
  assign fill_en       = (r_state == ST_FILL) && !r_stale && !w_inv_hit;
  assign fill_addr     = r_addr;
  assign fill_data     = r_data;
  assign mem_req_valid = (r_state == ST_MEM_REQ);
  assign mem_req_addr  = {r_addr[ADDR_W-1:OFF_HI+1], {OFF_W{1'b0}}};

  assign w_hit_inc  = (r_state == ST_LOOKUP) && hit;
  assign w_miss_inc = (r_state == ST_LOOKUP) && !hit;

  ysyx_22041207_sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_hit_inc),
    .count (hit_cnt)
  );

  ysyx_22041207_sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_miss_inc),
    .count (miss_cnt)
  );

endmodule

// File: tb/tb_ysyx_22041207_cache_refill.sv
// Self-checking bench for the cache refill controller; a second instance with
// 2-bit counters exercises counter saturation.
module tb_ysyx_22041207_cache_refill;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, hit, inv_valid, mem_req_ready, mem_rsp_valid;
  logic [63:0] req_addr, hit_data, inv_addr, mem_rsp_data;
  logic        req_ready, rsp_valid, fill_en, mem_req_valid;
  logic [63:0] rsp_data, lookup_addr, fill_addr, fill_data, mem_req_addr;
  logic [31:0] hit_cnt, miss_cnt;

  logic        req_valid2;
  logic        req_ready2, rsp_valid2, fill_en2, mem_req_valid2;
  logic [63:0] rsp_data2, lookup_addr2, fill_addr2, fill_data2, mem_req_addr2;
  logic [1:0]  hit_cnt2, miss_cnt2;

  int n_checks = 0;
  int n_errors = 0;
  int exp_hits = 0;
  int exp_misses = 0;
  logic [63:0] exp_q[$];

  int          r_lat, r_nfill, r_nmreq, r_fillc;
  logic [63:0] r_maddr, r_faddr, r_fdata, r_rdata, r_look;
  logic        r_mstable;

  always #5 clk = ~clk;

  ysyx_22041207_cache_refill #(.ADDR_W(64), .DATA_W(64), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .lookup_addr(lookup_addr), .hit(hit), .hit_data(hit_data),
    .fill_en(fill_en), .fill_addr(fill_addr), .fill_data(fill_data),
    .inv_valid(inv_valid), .inv_addr(inv_addr),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  ysyx_22041207_cache_refill #(.ADDR_W(64), .DATA_W(64), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_addr(64'h100),
    .req_ready(req_ready2), .rsp_valid(rsp_valid2), .rsp_data(rsp_data2),
    .lookup_addr(lookup_addr2), .hit(1'b1), .hit_data(64'h77),
    .fill_en(fill_en2), .fill_addr(fill_addr2), .fill_data(fill_data2),
    .inv_valid(1'b0), .inv_addr(64'h0),
    .mem_req_valid(mem_req_valid2), .mem_req_ready(1'b0),
    .mem_req_addr(mem_req_addr2), .mem_rsp_valid(1'b0),
    .mem_rsp_data(64'h0), .hit_cnt(hit_cnt2), .miss_cnt(miss_cnt2)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Issues one load and plays the memory side: ready on memory-cycle rd,
  // data on memory-cycle rs (counted from the first mem_req_valid cycle).
  task automatic run_txn(input logic [63:0] addr, input logic h, input logic [63:0] hdata,
                         input int rd, input int rs, input logic [63:0] mdata,
                         input int inv_k, input logic [63:0] inv_a, input logic junk);
    int k;
    req_valid = 1'b1; req_addr = addr; hit = h; hit_data = hdata;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; inv_valid = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = ~addr;
    r_lat = -1; r_nfill = 0; r_nmreq = 0; r_fillc = -1; r_mstable = 1'b1;
    r_maddr = '0; r_faddr = '0; r_fdata = '0; r_rdata = '0; r_look = lookup_addr;
    k = -1;
    for (int c = 1; c <= 64; c++) begin
      if (k < 0 && mem_req_valid) k = 0;
      mem_req_ready = (k == rd);
      mem_rsp_valid = (k >= 0) ? (k == rs) : junk;
      mem_rsp_data  = (k == rs) ? mdata : 64'hBAD0_BAD0_BAD0_BAD0;
      inv_valid     = (k >= 0) && (k == inv_k);
      inv_addr      = inv_a;
      #1;
      if (fill_en) begin
        r_nfill++; r_faddr = fill_addr; r_fdata = fill_data; r_fillc = c;
      end
      if (mem_req_valid) begin
        if (r_nmreq == 0) r_maddr = mem_req_addr;
        else if (mem_req_addr !== r_maddr) r_mstable = 1'b0;
        r_nmreq++;
      end
      if (rsp_valid) begin
        r_lat = c; r_rdata = rsp_data;
        break;
      end
      @(posedge clk); #1;
      if (k >= 0) k++;
    end
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; inv_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    req_valid = 0; req_addr = '0; hit = 0; hit_data = '0; inv_valid = 0; inv_addr = '0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0; req_valid2 = 0;
    rst = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready);
    end
    n_checks++;
    if ({rsp_valid, fill_en, mem_req_valid} !== 3'b000) begin
      n_errors++; $display("FAIL reset_strobes: got %b expected 000", {rsp_valid, fill_en, mem_req_valid});
    end
    n_checks++;
    if ({rsp_data, fill_addr, fill_data, mem_req_addr, lookup_addr} !== '0) begin
      n_errors++; $display("FAIL reset_buses: rsp_data %h fill_addr %h fill_data %h mem_req_addr %h lookup_addr %h expected all 0",
                           rsp_data, fill_addr, fill_data, mem_req_addr, lookup_addr);
    end
    n_checks++;
    if ({hit_cnt, miss_cnt} !== 64'h0) begin
      n_errors++; $display("FAIL reset_counters: hit %0d miss %0d expected 0 0", hit_cnt, miss_cnt);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_hit();
    logic [63:0] e;
    exp_q.push_back(64'hDEAD);
    run_txn(64'h8000_0010, 1'b1, 64'hDEAD, 0, 0, 64'h0, -1, 64'h0, 1'b1);
    exp_hits++;
    e = exp_q.pop_front();
    n_checks++;
    if (r_lat !== 2) begin n_errors++; $display("FAIL hit_latency: got %0d expected 2", r_lat); end
    n_checks++;
    if (r_rdata !== e) begin n_errors++; $display("FAIL hit_data: got %h expected %h", r_rdata, e); end
    n_checks++;
    if (r_look !== 64'h8000_0010) begin
      n_errors++; $display("FAIL hit_lookup_addr: got %h expected 80000010", r_look);
    end
    n_checks++;
    if (r_nmreq !== 0 || r_nfill !== 0) begin
      n_errors++; $display("FAIL hit_no_mem: mem_req cycles %0d fills %0d expected 0 0", r_nmreq, r_nfill);
    end
    n_checks++;
    if (hit_cnt !== 32'(exp_hits) || miss_cnt !== 32'(exp_misses)) begin
      n_errors++; $display("FAIL hit_counters: got %0d/%0d expected %0d/%0d", hit_cnt, miss_cnt, exp_hits, exp_misses);
    end
  endtask

  task automatic test_miss();
    logic [63:0] e;
    exp_q.push_back(64'h1234);
    run_txn(64'h8000_0014, 1'b0, 64'hFFFF, 3, 5, 64'h1234, -1, 64'h0, 1'b0);
    exp_misses++;
    e = exp_q.pop_front();
    n_checks++;
    if (r_lat !== 9) begin n_errors++; $display("FAIL miss_latency: got %0d expected 9", r_lat); end
    n_checks++;
    if (r_rdata !== e) begin n_errors++; $display("FAIL miss_data: got %h expected %h", r_rdata, e); end
    n_checks++;
    if (r_maddr !== 64'h8000_0010 || r_mstable !== 1'b1 || r_nmreq !== 4) begin
      n_errors++; $display("FAIL miss_mem_req: addr %h stable %b cycles %0d expected 80000010 1 4", r_maddr, r_mstable, r_nmreq);
    end
    n_checks++;
    if (r_nfill !== 1 || r_faddr !== 64'h8000_0014 || r_fdata !== 64'h1234) begin
      n_errors++; $display("FAIL miss_fill: count %0d addr %h data %h expected 1 80000014 1234", r_nfill, r_faddr, r_fdata);
    end
    n_checks++;
    if (hit_cnt !== 32'(exp_hits) || miss_cnt !== 32'(exp_misses)) begin
      n_errors++; $display("FAIL miss_counters: got %0d/%0d expected %0d/%0d", hit_cnt, miss_cnt, exp_hits, exp_misses);
    end
  endtask

  task automatic test_same_cycle();
    logic [63:0] e;
    exp_q.push_back(64'hCAFE);
    run_txn(64'h8000_0028, 1'b0, 64'h0, 0, 0, 64'hCAFE, -1, 64'h0, 1'b0);
    exp_misses++;
    e = exp_q.pop_front();
    n_checks++;
    if (r_lat !== 4 || r_fillc !== 3 || r_nmreq !== 1) begin
      n_errors++; $display("FAIL same_cycle_timing: rsp %0d fill %0d mem cycles %0d expected 4 3 1", r_lat, r_fillc, r_nmreq);
    end
    n_checks++;
    if (r_rdata !== e || r_fdata !== e || r_maddr !== 64'h8000_0028) begin
      n_errors++; $display("FAIL same_cycle_data: rsp %h fill %h maddr %h expected %h %h 80000028", r_rdata, r_fdata, r_maddr, e, e);
    end
  endtask

  task automatic test_invalidate();
    int          t_k[4]    = '{2, 0, 2, 2};
    logic [63:0] t_a[4]    = '{64'h8000_0010, 64'h8000_0017, 64'h8000_0018, 64'h9000_0014};
    int          t_fill[4] = '{0, 0, 1, 1};
    logic [63:0] e;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(64'h5678 + 64'(i));
      run_txn(64'h8000_0014, 1'b0, 64'h0, 1, 4, 64'h5678 + 64'(i), t_k[i], t_a[i], 1'b0);
      exp_misses++;
      e = exp_q.pop_front();
      n_checks++;
      if (r_nfill !== t_fill[i]) begin
        n_errors++; $display("FAIL inv_fill[%0d]: fills %0d expected %0d", i, r_nfill, t_fill[i]);
      end
      n_checks++;
      if (r_lat !== 8 || r_rdata !== e) begin
        n_errors++; $display("FAIL inv_rsp[%0d]: latency %0d data %h expected 8 %h", i, r_lat, r_rdata, e);
      end
    end
    n_checks++;
    if (miss_cnt !== 32'(exp_misses)) begin
      n_errors++; $display("FAIL inv_miss_cnt: got %0d expected %0d", miss_cnt, exp_misses);
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    logic [63:0] e;
    hit = 1'b1; hit_data = 64'hA1; req_addr = 64'h8000_0100; req_valid = 1'b1;
    exp_q.push_back(64'hA1);
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        n_checks++;
        if (req_ready !== 1'b0) begin n_errors++; $display("FAIL b2b_busy_ready: got %b expected 0", req_ready); end
      end
      if (c == 3) begin
        hit_data = 64'hB2; exp_q.push_back(64'hB2);
      end
      if (c == 6) req_valid = 1'b0;
      if (rsp_valid) begin
        pulses++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hX;
        n_checks++;
        if (rsp_data !== e) begin n_errors++; $display("FAIL b2b_data: got %h expected %h", rsp_data, e); end
      end
    end
    exp_hits += 2;
    n_checks++;
    if (pulses !== 2 || hit_cnt !== 32'(exp_hits)) begin
      n_errors++; $display("FAIL b2b_count: pulses %0d hit_cnt %0d expected 2 %0d", pulses, hit_cnt, exp_hits);
    end
    hit = 1'b0;
  endtask

  task automatic test_reset_mid_miss();
    int bad = 0;
    req_valid = 1'b1; req_addr = 64'h8000_0040; hit = 1'b0;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1; mem_req_ready = 1'b1;
    @(posedge clk); #1; mem_req_ready = 1'b0;
    n_checks++;
    if (mem_req_valid !== 1'b0 || req_ready !== 1'b0) begin
      n_errors++; $display("FAIL mid_miss_wait: mem_req_valid %b req_ready %b expected 0 0", mem_req_valid, req_ready);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin
      n_errors++; $display("FAIL async_reset: req_ready %b hit %0d miss %0d expected 1 0 0", req_ready, hit_cnt, miss_cnt);
    end
    @(posedge clk); #1; rst = 1'b0;
    exp_hits = 0; exp_misses = 0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 64'h9999;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
      if (fill_en || rsp_valid || !req_ready || mem_req_valid) bad++;
    end
    n_checks++;
    if (bad !== 0 || hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin
      n_errors++; $display("FAIL late_mem_rsp: bad cycles %0d hit %0d miss %0d expected 0 0 0", bad, hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_saturation();
    int bad = 0;
    for (int i = 0; i < 5; i++) begin
      req_valid2 = 1'b1;
      @(posedge clk); #1; req_valid2 = 1'b0;
      if (fill_en2 || mem_req_valid2) bad++;
      if (i == 0) begin
        n_checks++;
        if (lookup_addr2 !== 64'h100 || mem_req_addr2 !== 64'h100) begin
          n_errors++; $display("FAIL sat_lookup: lookup %h mem_addr %h expected 100 100", lookup_addr2, mem_req_addr2);
        end
      end
      @(posedge clk); #1;
      if (fill_en2 || mem_req_valid2) bad++;
      if (i == 0) begin
        n_checks++;
        if (rsp_valid2 !== 1'b1 || rsp_data2 !== 64'h77) begin
          n_errors++; $display("FAIL sat_rsp: valid %b data %h expected 1 77", rsp_valid2, rsp_data2);
        end
      end
      @(posedge clk); #1;
      if (i == 1) begin
        n_checks++;
        if (hit_cnt2 !== 2'd2) begin n_errors++; $display("FAIL sat_preload: got %0d expected 2", hit_cnt2); end
      end
    end
    n_checks++;
    if (hit_cnt2 !== 2'b11 || miss_cnt2 !== 2'b00) begin
      n_errors++; $display("FAIL sat_hit_cnt: hit %0d miss %0d expected 3 0", hit_cnt2, miss_cnt2);
    end
    n_checks++;
    if (bad !== 0 || req_ready2 !== 1'b1 || fill_addr2 !== 64'h100 || fill_data2 !== 64'h77) begin
      n_errors++; $display("FAIL sat_side: bad %0d ready %b fill_addr %h fill_data %h expected 0 1 100 77",
                           bad, req_ready2, fill_addr2, fill_data2);
    end
    n_checks++;
    if (hit_cnt !== 32'(exp_hits)) begin
      n_errors++; $display("FAIL main_hit_cnt_isolated: got %0d expected %0d", hit_cnt, exp_hits);
    end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_miss();
    test_same_cycle();
    test_invalidate();
    test_back_to_back();
    test_reset_mid_miss();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
